// File: rtl/regfile_pkg.sv
// Shared register-file types: register count, data width and address width.
// Used by the writeback arbiter and by the register file.
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_WIDTH = 32;
  localparam int AW        = $clog2(REG_COUNT);

  typedef logic [AW-1:0]        reg_addr_t;
  typedef logic [REG_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/RegisterFile.sv
// Register file with one write port and two registered read ports.
// A read and a write to the same address in the same cycle return the old data.
module RegisterFile
  import regfile_pkg::*;
(
  input  logic      clk_i,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  reg_data_t wdata_i,
  input  reg_addr_t raddr_1_i,
  input  reg_addr_t raddr_2_i,
  output reg_data_t rdata_1_o,
  output reg_data_t rdata_2_o
);

  reg_data_t r_mem [REG_COUNT];
  reg_data_t r_rdata_1_p1;
  reg_data_t r_rdata_2_p1;

  // Write port; contents are deliberately not cleared by any reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  // Registered reads; sampling the array before this edge's write gives old data.
  always_ff @(posedge clk_i) begin
    r_rdata_1_p1 <= r_mem[raddr_1_i];
    r_rdata_2_p1 <= r_mem[raddr_2_i];
  end

  assign rdata_1_o = r_rdata_1_p1;
  assign rdata_2_o = r_rdata_2_p1;

endmodule

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i
// (wrapping modulo N) wins while en_i is high. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  int            w_cand;
  logic [IW-1:0] w_idx;

  // Scan N positions starting at the pointer; the first valid request wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    w_cand    = 0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(ptr_i) + k) % N;
      w_idx  = IW'(w_cand);
      if (en_i && !gnt_vld_o && req_i[w_idx]) begin
        gnt_vld_o    = 1'b1;
        gnt_idx_o    = w_idx;
        gnt_o[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback sources.
// Round-robin grant, one registered write stage, and write-to-read bypass info
// aligned with the register file's 1-cycle read data.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  reg_addr_t [NUM_REQ-1:0] req_addr_i,
  input  reg_data_t [NUM_REQ-1:0] req_data_i,
  input  logic                    stall_i,
  output reg_addr_t               wr_addr_o,
  output reg_data_t               wr_data_o,
  output logic                    wr_en_o,
  input  reg_addr_t               rd_addr_1_i,
  input  reg_addr_t               rd_addr_2_i,
  output logic                    byp_hit_1_o,
  output reg_data_t               byp_data_1_o,
  output logic                    byp_hit_2_o,
  output reg_data_t               byp_data_2_o
);

  logic [IW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gnt_idx;
  logic               w_gnt_vld;
  logic               w_arb_en;
  logic               w_wr_en;

  logic               r_wr_en_p1;
  reg_addr_t          r_wr_addr_p1;
  reg_data_t          r_wr_data_p1;

  logic               r_byp_hit_1_p2;
  logic               r_byp_hit_2_p2;
  reg_data_t          r_byp_data_1_p2;
  reg_data_t          r_byp_data_2_p2;

  assign w_arb_en = !stall_i && !reset_i;

  // ---- stage p0: combinational grant ----
  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i     (req_valid_i),
    .ptr_i     (r_ptr),
    .en_i      (w_arb_en),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx),
    .gnt_vld_o (w_gnt_vld)
  );

  // The grant only asserts on a valid request, so any grant is a handshake.
  assign req_ready_o = w_gnt;

  // Pointer moves one past the winner on a handshake and holds otherwise.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      if (w_gnt_idx == IW'(NUM_REQ - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_gnt_idx + 1'b1;
      end
    end
  end

  // ---- stage p1: registered regfile write ----
  // Capture the winning write; address/data only load on a handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_en_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else begin
      r_wr_en_p1 <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_wr_addr_p1 <= req_addr_i[w_gnt_idx];
        r_wr_data_p1 <= req_data_i[w_gnt_idx];
      end
    end
  end

  // A write still held here when reset arrives is dropped before reaching the file.
  assign w_wr_en   = r_wr_en_p1 && !reset_i;
  assign wr_en_o   = w_wr_en;
  assign wr_addr_o = r_wr_addr_p1;
  assign wr_data_o = r_wr_data_p1;

  // ---- stage p2: bypass info aligned with the file's read data ----
  // Flag reads that see pre-write data this cycle and forward the write value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_byp_hit_1_p2  <= 1'b0;
      r_byp_hit_2_p2  <= 1'b0;
      r_byp_data_1_p2 <= '0;
      r_byp_data_2_p2 <= '0;
    end else begin
      r_byp_hit_1_p2  <= w_wr_en && (rd_addr_1_i == r_wr_addr_p1);
      r_byp_hit_2_p2  <= w_wr_en && (rd_addr_2_i == r_wr_addr_p1);
      r_byp_data_1_p2 <= r_wr_data_p1;
      r_byp_data_2_p2 <= r_wr_data_p1;
    end
  end

  assign byp_hit_1_o  = r_byp_hit_1_p2;
  assign byp_hit_2_o  = r_byp_hit_2_p2;
  assign byp_data_1_o = r_byp_data_1_p2;
  assign byp_data_2_o = r_byp_data_2_p2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter together with RegisterFile: a cycle model of
// the arbitration rules and register contents plus directed literal checks.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N = 3;

  logic               clk;
  logic               reset_i;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  reg_addr_t [N-1:0]  req_addr;
  reg_data_t [N-1:0]  req_data;
  logic               stall;
  reg_addr_t          wr_addr;
  reg_data_t          wr_data;
  logic               wr_en;
  reg_addr_t          rd_addr_1;
  reg_addr_t          rd_addr_2;
  logic               byp_hit_1;
  logic               byp_hit_2;
  reg_data_t          byp_data_1;
  reg_data_t          byp_data_2;
  reg_data_t          rd_data_1;
  reg_data_t          rd_data_2;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .stall_i      (stall),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .wr_en_o      (wr_en),
    .rd_addr_1_i  (rd_addr_1),
    .rd_addr_2_i  (rd_addr_2),
    .byp_hit_1_o  (byp_hit_1),
    .byp_data_1_o (byp_data_1),
    .byp_hit_2_o  (byp_hit_2),
    .byp_data_2_o (byp_data_2)
  );

  RegisterFile u_rf (
    .clk_i     (clk),
    .we_i      (wr_en),
    .waddr_i   (wr_addr),
    .wdata_i   (wr_data),
    .raddr_1_i (rd_addr_1),
    .raddr_2_i (rd_addr_2),
    .rdata_1_o (rd_data_1),
    .rdata_2_o (rd_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int        m_ptr = 0;
  bit        m_known = 0;
  bit        m_wen = 0;
  reg_addr_t m_waddr = '0;
  reg_data_t m_wdata = '0;
  bit        m_hit1 = 0, m_hit2 = 0;
  reg_data_t m_bd1 = '0, m_bd2 = '0;
  reg_data_t m_ram [REG_COUNT];
  bit        m_written [REG_COUNT];
  bit        m_rdv1 = 0, m_rdv2 = 0;
  reg_data_t m_rd1 = '0, m_rd2 = '0;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int           gi;
    bit           hs;
    bit           eff_wen;
    exp_rdy = '0;
    gi      = 0;
    hs      = 0;
    if (!reset_i && !stall) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req_valid[j]) begin
          gi = j;
          hs = 1;
          break;
        end
      end
    end
    if (hs) exp_rdy[gi] = 1'b1;
    eff_wen = m_wen && !reset_i;

    chk("m_ready", req_ready, exp_rdy);
    if (m_known) begin
      chk("m_wr_en", wr_en, eff_wen);
      if (eff_wen) begin
        chk("m_wr_addr", wr_addr, m_waddr);
        chk("m_wr_data", wr_data, m_wdata);
      end
      chk("m_hit1", byp_hit_1, m_hit1);
      chk("m_hit2", byp_hit_2, m_hit2);
      if (m_hit1) chk("m_bdata1", byp_data_1, m_bd1);
      if (m_hit2) chk("m_bdata2", byp_data_2, m_bd2);
    end
    if (m_rdv1) chk("m_rdata1", rd_data_1, m_rd1);
    if (m_rdv2) chk("m_rdata2", rd_data_2, m_rd2);

    // reads see the array before this cycle's write
    m_rdv1 = m_written[rd_addr_1];
    m_rd1  = m_ram[rd_addr_1];
    m_rdv2 = m_written[rd_addr_2];
    m_rd2  = m_ram[rd_addr_2];
    if (m_known && eff_wen) begin
      m_ram[m_waddr]     = m_wdata;
      m_written[m_waddr] = 1'b1;
    end

    if (reset_i) begin
      m_ptr   = 0;
      m_wen   = 0;
      m_hit1  = 0;
      m_hit2  = 0;
      m_known = 1;
    end else begin
      m_hit1 = m_known && eff_wen && (rd_addr_1 == m_waddr);
      m_hit2 = m_known && eff_wen && (rd_addr_2 == m_waddr);
      m_bd1  = m_wdata;
      m_bd2  = m_wdata;
      m_wen  = hs;
      if (hs) begin
        m_waddr = req_addr[gi];
        m_wdata = req_data[gi];
        m_ptr   = (gi + 1) % N;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [N-1:0] seq [6];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    reset_i   = 1'b1;
    req_valid = 3'b111;
    stall     = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    rd_addr_1 = '0;
    rd_addr_2 = '0;

    // 1: reset held two cycles with all valids high
    @(negedge clk);
    chk("rst_ready0", req_ready, 3'b000);
    tick();
    @(negedge clk);
    chk("rst_ready1", req_ready, 3'b000);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_hit1", byp_hit_1, 1'b0);
    chk("rst_hit2", byp_hit_2, 1'b0);
    tick();

    // 2: single write from req0
    reset_i     = 1'b0;
    req_valid   = 3'b001;
    req_addr[0] = 5'd5;
    req_data[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("single_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    chk("single_wr_en", wr_en, 1'b1);
    chk("single_wr_addr", wr_addr, 5'd5);
    chk("single_wr_data", wr_data, 32'hDEADBEEF);
    tick();
    tick();
    rd_addr_1 = 5'd5;
    tick();
    @(negedge clk);
    chk("single_read", rd_data_1, 32'hDEADBEEF);
    tick();

    // 3: round robin (pointer is 1 here; a lone req2 brings it back to 0)
    req_addr[0] = 5'd10; req_data[0] = 32'hA0A0_0000;
    req_addr[1] = 5'd11; req_data[1] = 32'hB1B1_1111;
    req_addr[2] = 5'd12; req_data[2] = 32'hC2C2_2222;
    req_valid   = 3'b100;
    @(negedge clk);
    chk("rr_pre", req_ready, 3'b100);
    tick();
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_seq", req_ready, seq[i]);
      tick();
    end
    req_valid = 3'b110;
    @(negedge clk);
    chk("rr_g1", req_ready, 3'b010);
    tick();
    @(negedge clk);
    chk("rr_g2", req_ready, 3'b100);
    tick();
    req_valid = 3'b000;
    tick();

    // 4: stall three cycles, then resume at the same index
    req_valid = 3'b111;
    stall     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", req_ready, 3'b000);
      chk("stall_wr_en", wr_en, 1'b0);
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("stall_resume", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    tick();

    // 5: bypass on both ports, then a non-matching read
    req_valid   = 3'b010;
    req_addr[1] = 5'd7;
    req_data[1] = 32'h0000_1234;
    @(negedge clk);
    chk("byp_ready", req_ready, 3'b010);
    tick();
    req_valid = 3'b000;
    rd_addr_1 = 5'd7;
    rd_addr_2 = 5'd7;
    @(negedge clk);
    chk("byp_wr_en", wr_en, 1'b1);
    tick();
    @(negedge clk);
    chk("byp_hit1", byp_hit_1, 1'b1);
    chk("byp_hit2", byp_hit_2, 1'b1);
    chk("byp_data1", byp_data_1, 32'h0000_1234);
    chk("byp_data2", byp_data_2, 32'h0000_1234);
    req_valid   = 3'b100;
    req_addr[2] = 5'd7;
    req_data[2] = 32'h0000_5678;
    tick();
    req_valid = 3'b000;
    rd_addr_1 = 5'd8;
    rd_addr_2 = 5'd8;
    tick();
    @(negedge clk);
    chk("nobyp_hit1", byp_hit_1, 1'b0);
    chk("nobyp_hit2", byp_hit_2, 1'b0);
    tick();

    // 6: reset right after a handshake drops the write
    req_valid   = 3'b010;
    req_addr[1] = 5'd5;
    req_data[1] = 32'h0000_CAFE;
    @(negedge clk);
    chk("rst_mid_ready", req_ready, 3'b010);
    tick();
    reset_i   = 1'b1;
    req_valid = 3'b000;
    @(negedge clk);
    chk("rst_mid_wr_en", wr_en, 1'b0);
    tick();
    reset_i   = 1'b0;
    req_valid = 3'b111;
    @(negedge clk);
    chk("rst_after_wr_en", wr_en, 1'b0);
    chk("rst_after_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    rd_addr_1 = 5'd5;
    tick();
    @(negedge clk);
    chk("rst_ram_kept", rd_data_1, 32'hDEADBEEF);
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
